// File: rtl/lcd_pcf8574_writer.sv
// Serialises a 3-character message onto an I2C bus as a single write to a
// PCF8574 LCD backpack: cursor to line 1 col 0, then three HD44780 4-bit
// character writes. Open-drain outputs: *_oe=1 pulls the line low.
module lcd_pcf8574_writer #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] I2C_ADDR = 7'h27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] msg_data,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        scl_oe,
    output logic        busy,
    output logic        done,
    output logic        ack_error
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [1:0]        phase;
    logic [2:0]        bit_cnt;
    logic [4:0]        idx;
    logic              ack_sample;
    logic [23:0]       msg_q;
    logic              accept, active, tick, phase_end, cur_bit;
    logic [7:0]        cur_byte;

    // Byte idx of the transaction: address, cursor command, then 4 nibble
    // writes per character ({D7..D4, BL=1, EN, RW=0, RS=1}, EN high then low).
    function automatic logic [7:0] payload_byte(input logic [4:0] i, input logic [23:0] m);
        logic [3:0] k;
        logic [7:0] c;
        logic [3:0] nib;
        logic [7:0] b;
        k = 4'(i - 5'd5);
        case (k[3:2])
            2'd0:    c = m[23:16];
            2'd1:    c = m[15:8];
            default: c = m[7:0];
        endcase
        nib = k[1] ? c[3:0] : c[7:4];
        case (i)
            5'd0:    b = {I2C_ADDR, 1'b0};
            5'd1:    b = 8'h8C;
            5'd2:    b = 8'h88;
            5'd3:    b = 8'h0C;
            5'd4:    b = 8'h08;
            default: b = {nib, k[0] ? 4'h9 : 4'hD};
        endcase
        return b;
    endfunction

    assign accept    = msg_valid && (state == S_IDLE);
    assign active    = (state == S_START) || (state == S_BIT) ||
                       (state == S_ACK)   || (state == S_STOP);
    assign tick      = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign phase_end = tick && (phase == 2'd3);
    assign cur_byte  = payload_byte(idx, msg_q);
    assign cur_bit   = cur_byte[bit_cnt];

    assign msg_ready = (state == S_IDLE);
    assign busy      = active;
    assign done      = (state == S_DONE);

    // State register; reset drops straight to IDLE so both lines release at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: each bus state lasts four phases; ACK decides continue/stop.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (msg_valid) state_nxt = S_START;
            S_START: if (phase_end) state_nxt = S_BIT;
            S_BIT:   if (phase_end) state_nxt = (bit_cnt == 3'd0) ? S_ACK : S_BIT;
            S_ACK:   if (phase_end) begin
                         if (ack_sample || idx == 5'd16) state_nxt = S_STOP;
                         else                             state_nxt = S_BIT;
                     end
            S_STOP:  if (phase_end) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus line levels as a function of state and quarter-bit phase.
    always_comb begin
        sda_oe = 1'b0;
        scl_oe = 1'b0;
        case (state)
            S_START: begin
                sda_oe = (phase != 2'd0);
                scl_oe = (phase == 2'd3);
            end
            S_BIT: begin
                scl_oe = !phase[1];
                sda_oe = !cur_bit;
            end
            S_ACK: begin
                scl_oe = !phase[1];
            end
            S_STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = (phase != 2'd3);
            end
            default: ;
        endcase
    end

    // Quarter-bit divider; idles at zero so every frame starts phase-aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                div_cnt <= '0;
        else if (!active || tick) div_cnt <= '0;
        else                      div_cnt <= div_cnt + DIV_W'(1);
    end

    // Phase 0..3 within the current bus symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        phase <= 2'd0;
        else if (!active) phase <= 2'd0;
        else if (tick)    phase <= phase + 2'd1;
    end

    // Bit/byte position, ACK sample and sticky NACK flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 3'd7;
            idx        <= 5'd0;
            ack_sample <= 1'b0;
            ack_error  <= 1'b0;
        end else begin
            if (accept) begin
                bit_cnt   <= 3'd7;
                idx       <= 5'd0;
                ack_error <= 1'b0;
            end
            if (state == S_BIT && phase_end)
                bit_cnt <= bit_cnt - 3'd1;
            if (state == S_ACK && tick && phase == 2'd2)
                ack_sample <= sda_in;
            if (state == S_ACK && phase_end) begin
                if (ack_sample)          ack_error <= 1'b1;
                else if (idx != 5'd16)   idx <= idx + 5'd1;
            end
        end
    end

    // Message is captured on acceptance so later input changes do not leak in.
    always_ff @(posedge clk) begin
        if (accept) msg_q <= msg_data;
    end

endmodule

// File: tb/tb_lcd_pcf8574_writer.sv
// Bench for lcd_pcf8574_writer: an I2C slave model decodes the bus, a bus
// monitor counts START/STOP conditions, and a payload model built from the
// LCD/backpack byte rules supplies the expected bytes.
module tb_lcd_pcf8574_writer;

    localparam int CLK_DIV = 2;
    localparam int FRAME_CYC = 155 * 4 * CLK_DIV;
    localparam int NACK_CYC  = (1 + 9 + 1) * 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] msg_data = 24'h0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic        sda_in;
    logic        sda_oe;
    logic        scl_oe;
    logic        busy;
    logic        done;
    logic        ack_error;

    int errors = 0;
    int checks = 0;

    // slave / monitor state
    logic       slave_drv = 1'b0;
    bit         nack_addr = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    bit         in_frame = 1'b0;
    int         bitcnt = 0;
    int         byte_in_frame = 0;
    logic [7:0] shreg = 8'h0;
    int         starts = 0;
    int         stops = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit         exp_ack_err = 1'b0;

    assign sda_in = ~(sda_oe | slave_drv);

    lcd_pcf8574_writer #(.CLK_DIV(CLK_DIV), .I2C_ADDR(7'h27)) dut (
        .clk(clk), .reset(reset),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .sda_in(sda_in), .sda_oe(sda_oe), .scl_oe(scl_oe),
        .busy(busy), .done(done), .ack_error(ack_error)
    );

    always #5 clk = ~clk;

    // Slave + protocol monitor, sampling mid-cycle
    always @(negedge clk) begin
        logic scl_b, sda_b;
        scl_b = ~scl_oe;
        sda_b = ~(sda_oe | slave_drv);
        if (reset) begin
            slave_drv = 1'b0;
            in_frame  = 1'b0;
            bitcnt    = 0;
        end else if (scl_b && prev_scl && sda_b != prev_sda) begin
            if (!sda_b) begin
                starts++;
                in_frame = 1'b1;
                bitcnt = 0;
                byte_in_frame = 0;
            end else begin
                stops++;
                in_frame = 1'b0;
                slave_drv = 1'b0;
            end
        end else if (in_frame && scl_b && !prev_scl) begin
            if (bitcnt < 8) begin
                shreg = {shreg[6:0], sda_b};
                bitcnt++;
                if (bitcnt == 8) begin
                    rx_q.push_back(shreg);
                    byte_in_frame++;
                end
            end else begin
                bitcnt = 9;
            end
        end else if (in_frame && !scl_b && prev_scl) begin
            if (bitcnt == 8) begin
                slave_drv = !(nack_addr && byte_in_frame == 1);
            end else if (bitcnt == 9) begin
                slave_drv = 1'b0;
                bitcnt = 0;
            end
        end
        prev_scl = reset ? 1'b1 : scl_b;
        prev_sda = reset ? 1'b1 : ~(sda_oe | slave_drv);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected payload from the backpack rules: address, cursor cmd 0x80 as
    // two nibbles with EN pulsed, then each char as high/low nibble with RS=1.
    task automatic build_exp(input logic [23:0] m);
        logic [7:0] c;
        logic [7:0] cmd;
        exp_q.delete();
        exp_q.push_back({7'h27, 1'b0});
        cmd = 8'h80;
        exp_q.push_back({cmd[7:4], 4'b1100});
        exp_q.push_back({cmd[7:4], 4'b1000});
        exp_q.push_back({cmd[3:0], 4'b1100});
        exp_q.push_back({cmd[3:0], 4'b1000});
        for (int k = 0; k < 3; k++) begin
            c = 8'(m >> (16 - 8 * k));
            exp_q.push_back({c[7:4], 4'b1101});
            exp_q.push_back({c[7:4], 4'b1001});
            exp_q.push_back({c[3:0], 4'b1101});
            exp_q.push_back({c[3:0], 4'b1001});
        end
    endtask

    task automatic compare_rx(input string tag);
        logic [7:0] obs;
        check({tag, ":nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("%s:byte%0d", tag, i), obs, exp_q[i]);
        end
    endtask

    // Waits (bounded) for done; counts cycles and ready/busy violations.
    task automatic wait_done(output int cyc, output bit got, output int viol);
        cyc = 0; got = 0; viol = 0;
        while (cyc < 3000 && !got) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) got = 1;
            else if (msg_ready !== 1'b0 || busy !== 1'b1) viol++;
        end
        if (got) begin
            check("busy_at_done", busy, 1'b0);
        end
    endtask

    task automatic run_frame(input string tag, input logic [23:0] m, input bit nack);
        int s0, p0, cyc, viol;
        bit got;
        nack_addr = nack;
        @(posedge clk);
        @(negedge clk);
        s0 = starts; p0 = stops;
        rx_q.delete();
        check({tag, ":ack_err_before"}, ack_error, exp_ack_err);
        check({tag, ":ready_idle"}, msg_ready, 1'b1);
        msg_data = m;
        msg_valid = 1'b1;
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        check({tag, ":ack_err_accept"}, ack_error, 1'b0);
        check({tag, ":ready_drop"}, msg_ready, 1'b0);
        check({tag, ":busy_accept"}, busy, 1'b1);
        msg_data = 24'($urandom);
        wait_done(cyc, got, viol);
        check({tag, ":done_seen"}, got, 1'b1);
        check({tag, ":latency"}, cyc, nack ? NACK_CYC : FRAME_CYC);
        check({tag, ":ready_busy_viol"}, viol, 0);
        check({tag, ":ack_err_end"}, ack_error, nack);
        exp_ack_err = nack;
        build_exp(m);
        if (nack) while (exp_q.size() > 1) void'(exp_q.pop_back());
        compare_rx(tag);
        check({tag, ":starts"}, starts - s0, 1);
        check({tag, ":stops"}, stops - p0, 1);
    endtask

    initial begin
        int s0, p0, cyc, viol;
        bit got;
        bit hit;

        // reset state
        #2 reset = 1'b1;
        #1;
        check("rst:sda_oe", sda_oe, 1'b0);
        check("rst:scl_oe", scl_oe, 1'b0);
        check("rst:ready", msg_ready, 1'b1);
        check("rst:busy", busy, 1'b0);
        check("rst:done", done, 1'b0);
        check("rst:ack_error", ack_error, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // basic "WAT" frame
        run_frame("t1", 24'h574154, 1'b0);
        // address NACK, then next accept clears ack_error
        run_frame("t2_nack", 24'($urandom), 1'b1);
        run_frame("t6_clear", 24'($urandom), 1'b0);
        // random messages
        for (int n = 0; n < 3; n++) begin
            run_frame($sformatf("rand%0d", n), 24'($urandom), 1'b0);
        end

        // continuous refresh with msg_data changing mid-frame
        nack_addr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s0 = starts; p0 = stops;
        rx_q.delete();
        msg_data = 24'h574154;
        msg_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t3:busy1", busy, 1'b1);
        @(negedge clk);
        msg_data = 24'h444F4E;
        wait_done(cyc, got, viol);
        check("t3:done1", got, 1'b1);
        check("t3:lat1", cyc, FRAME_CYC);
        check("t3:viol1", viol, 0);
        build_exp(24'h574154);
        compare_rx("t3_f1");
        rx_q.delete();
        @(posedge clk);
        #1;
        check("t3:idle_ready", msg_ready, 1'b1);
        check("t3:idle_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("t3:reaccept_busy", busy, 1'b1);
        check("t3:reaccept_ready", msg_ready, 1'b0);
        msg_valid = 1'b0;
        wait_done(cyc, got, viol);
        check("t3:done2", got, 1'b1);
        check("t3:viol2", viol, 0);
        build_exp(24'h444F4E);
        compare_rx("t3_f2");
        check("t3:starts", starts - s0, 2);
        check("t3:stops", stops - p0, 2);
        exp_ack_err = 1'b0;

        // reset during byte idx 7
        @(posedge clk);
        @(negedge clk);
        msg_data = 24'($urandom);
        msg_valid = 1'b1;
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            #1;
            hit = (byte_in_frame == 7 && bitcnt == 2 && scl_oe === 1'b1);
        end
        check("t4:reach_idx7", hit, 1'b1);
        reset = 1'b1;
        #1;
        check("t4:sda_oe", sda_oe, 1'b0);
        check("t4:scl_oe", scl_oe, 1'b0);
        check("t4:busy", busy, 1'b0);
        check("t4:ready", msg_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_ack_err = 1'b0;
        run_frame("t4_after", 24'($urandom), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
